// File: rtl/blink_mode_ctrl_if.sv
// ----------------------------------------------------------------------------
// blink_mode_ctrl_if
// Purpose : groups the raw push-button inputs and the registered LED blinker
//           control outputs of blink_mode_ctrl into one bundle.
// Signals : i_btn_mode   - raw mode button, asynchronous, high = pressed
//           i_btn_enable - raw enable button, asynchronous, high = pressed
//           o_enable     - registered blink enable
//           o_select0    - registered mode bit 0
//           o_select1    - registered mode bit 1
// Modports: slave  - the controller (buttons in, controls out)
//           master - the environment (drives buttons, observes controls)
// There is no valid/ready handshake on this bundle: buttons are plain levels
// and the outputs are plain registered levels, sampled whenever convenient.
// ----------------------------------------------------------------------------
interface blink_mode_ctrl_if;
    logic i_btn_mode;
    logic i_btn_enable;
    logic o_enable;
    logic o_select0;
    logic o_select1;

    modport slave (
        input  i_btn_mode,
        input  i_btn_enable,
        output o_enable,
        output o_select0,
        output o_select1
    );

    modport master (
        output i_btn_mode,
        output i_btn_enable,
        input  o_enable,
        input  o_select0,
        input  o_select1
    );
endinterface

// File: rtl/blink_mode_ctrl.sv
// ----------------------------------------------------------------------------
// blink_mode_ctrl
// Purpose : turns two raw push-buttons into LED blinker controls. Each button
//           is synchronized (two flops), debounced (level register plus a
//           32-bit disagreement counter) and edge-detected into a one-cycle
//           press pulse. A mode press steps a 2-bit mode 0->1->2->3->0; an
//           enable press toggles the blink enable.
// Ports   : i_clk   - system clock, rising edge active
//           i_rst_n - asynchronous active-low reset
//           bus     - blink_mode_ctrl_if.slave (buttons in, controls out)
// Params  : c_debounce_count - consecutive stable cycles needed to accept a
//           new button level (legal 2 .. 2^32-1)
// Latency : a stable new raw level seen at edge 1 reaches the outputs after
//           edge c_debounce_count+3 (2 sync, c_debounce_count-1 count,
//           1 accept + pulse, 1 output register).
// ----------------------------------------------------------------------------
module blink_mode_ctrl #(
    parameter logic [31:0] c_debounce_count = 32'd500_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    blink_mode_ctrl_if.slave  bus
);
    localparam logic [31:0] c_last = c_debounce_count - 32'd1;

    // Index 0 = mode button, index 1 = enable button.
    localparam int c_mode = 0;
    localparam int c_en   = 1;

    logic [1:0]  raw;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  deb;
    logic [1:0]  press;
    logic [31:0] cnt [2];
    logic [1:0]  mode;
    logic        enable;

    assign raw = {bus.i_btn_enable, bus.i_btn_mode};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_debounce
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                deb[g]   <= 1'b0;
                cnt[g]   <= 32'd0;
                press[g] <= 1'b0;
            end else begin
                press[g] <= 1'b0;
                if (sync2[g] == deb[g]) begin
                    cnt[g] <= 32'd0;
                end else if (cnt[g] == c_last) begin
                    // Accepting a new level; pulse only on the rising side.
                    deb[g]   <= sync2[g];
                    cnt[g]   <= 32'd0;
                    press[g] <= sync2[g];
                end else begin
                    cnt[g] <= cnt[g] + 32'd1;
                end
            end
        end
    end

    // Mode and enable react to their own pulses independently, so coincident
    // presses both land in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode   <= 2'd0;
            enable <= 1'b1;
        end else begin
            if (press[c_mode]) begin
                mode <= mode + 2'd1;
            end
            if (press[c_en]) begin
                enable <= ~enable;
            end
        end
    end

    assign bus.o_enable  = enable;
    assign bus.o_select0 = mode[0];
    assign bus.o_select1 = mode[1];
endmodule

// File: tb/tb_blink_mode_ctrl.sv
// ----------------------------------------------------------------------------
// tb_blink_mode_ctrl
// Directed bench for blink_mode_ctrl with c_debounce_count = 4. Inputs are
// changed 1 ns after a rising edge, so the next rising edge is "edge 1";
// outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_blink_mode_ctrl;
    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] exp_q[$];

    always #10 i_clk = ~i_clk;

    blink_mode_ctrl_if bus ();

    blink_mode_ctrl #(
        .c_debounce_count(32'd4)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    // ---------------------------------------------------------------- drivers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.i_btn_mode   = 1'b0;
        bus.i_btn_enable = 1'b0;
        i_rst_n          = 1'b0;
        step(2);
        i_rst_n = 1'b1;
        step(3);
    endtask

    task automatic press_mode();
        bus.i_btn_mode = 1'b1;
        step(10);
        bus.i_btn_mode = 1'b0;
        step(10);
    endtask

    task automatic press_enable();
        bus.i_btn_enable = 1'b1;
        step(10);
        bus.i_btn_enable = 1'b0;
        step(10);
    endtask

    function automatic logic [1:0] sel();
        return {bus.o_select1, bus.o_select0};
    endfunction

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        bus.i_btn_mode   = 1'b0;
        bus.i_btn_enable = 1'b0;
        i_rst_n          = 1'b0;
        step(2);
        n_cmp++;
        if (bus.o_enable !== 1'b1 || sel() !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_hold: enable=%b sel=%b required enable=1 sel=00",
                     bus.o_enable, sel());
        end
        i_rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step(1);
            n_cmp++;
            if (bus.o_enable !== 1'b1 || sel() !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_idle edge %0d: enable=%b sel=%b required enable=1 sel=00",
                         e, bus.o_enable, sel());
            end
        end
    endtask

    task automatic test_hold();
        logic [1:0] exp;
        do_reset();
        bus.i_btn_mode = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step(1);
            exp = (e >= 7) ? 2'b01 : 2'b00;
            n_cmp++;
            if (sel() !== exp || bus.o_enable !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_mode edge %0d: sel=%b enable=%b required sel=%b enable=1",
                         e, sel(), bus.o_enable, exp);
            end
        end
        bus.i_btn_mode = 1'b0;
        step(10);
        n_cmp++;
        if (sel() !== 2'b01) begin
            n_bad++;
            $display("FAIL release_no_pulse: sel=%b required 01", sel());
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp;
        do_reset();
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b00);
        for (int p = 0; p < 4; p++) begin
            press_mode();
            exp = exp_q.pop_front();
            n_cmp++;
            if (sel() !== exp || bus.o_enable !== 1'b1) begin
                n_bad++;
                $display("FAIL wrap press %0d: sel=%b enable=%b required sel=%b enable=1",
                         p, sel(), bus.o_enable, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic exp;
        do_reset();
        bus.i_btn_enable = 1'b1;
        step(3);
        bus.i_btn_enable = 1'b0;
        step(1);
        bus.i_btn_enable = 1'b1;
        step(3);
        n_cmp++;
        if (bus.o_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_no_toggle: enable=%b required 1", bus.o_enable);
        end
        // Stable high seen from edge 5: accepted at edge 10, output at edge 11.
        for (int e = 8; e <= 13; e++) begin
            step(1);
            exp = (e >= 11) ? 1'b0 : 1'b1;
            n_cmp++;
            if (bus.o_enable !== exp) begin
                n_bad++;
                $display("FAIL bounce_hold edge %0d: enable=%b required %b",
                         e, bus.o_enable, exp);
            end
        end
        bus.i_btn_enable = 1'b0;
        step(12);
        n_cmp++;
        if (bus.o_enable !== 1'b0 || sel() !== 2'b00) begin
            n_bad++;
            $display("FAIL bounce_final: enable=%b sel=%b required enable=0 sel=00",
                     bus.o_enable, sel());
        end
    endtask

    task automatic test_both();
        logic       exp_en;
        logic [1:0] exp_sel;
        do_reset();
        bus.i_btn_mode   = 1'b1;
        bus.i_btn_enable = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            exp_en  = (e >= 7) ? 1'b0 : 1'b1;
            exp_sel = (e >= 7) ? 2'b01 : 2'b00;
            n_cmp++;
            if (bus.o_enable !== exp_en || sel() !== exp_sel) begin
                n_bad++;
                $display("FAIL both edge %0d: enable=%b sel=%b required enable=%b sel=%b",
                         e, bus.o_enable, sel(), exp_en, exp_sel);
            end
        end
        bus.i_btn_mode   = 1'b0;
        bus.i_btn_enable = 1'b0;
        step(10);
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp;
        do_reset();
        press_mode();
        press_enable();
        n_cmp++;
        if (bus.o_enable !== 1'b0 || sel() !== 2'b01) begin
            n_bad++;
            $display("FAIL pre_reset_state: enable=%b sel=%b required enable=0 sel=01",
                     bus.o_enable, sel());
        end
        bus.i_btn_mode = 1'b1;
        step(5);
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_enable !== 1'b1 || sel() !== 2'b00) begin
            n_bad++;
            $display("FAIL async_reset: enable=%b sel=%b required enable=1 sel=00",
                     bus.o_enable, sel());
        end
        step(2);
        i_rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            exp = (e >= 7) ? 2'b01 : 2'b00;
            n_cmp++;
            if (sel() !== exp || bus.o_enable !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_mid edge %0d: sel=%b enable=%b required sel=%b enable=1",
                         e, sel(), bus.o_enable, exp);
            end
        end
        bus.i_btn_mode = 1'b0;
        step(5);
    endtask

    initial begin
        test_reset();
        test_hold();
        test_wrap();
        test_bounce();
        test_both();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
